// File: rtl/pipelined_alu.sv
// pipelined_alu: multi-cycle execute-stage ALU with valid/ready handshakes.
// Single-cycle ops (add/and/xor/sll/sub/sra) return one cycle after accept;
// mul iterates MUL_BITS multiplier bits per cycle through a shift-add unit.
// Optional macro ALU_MULH_EN turns opcode 111 into signed mulh (upper half
// of the 2*WIDTH product); otherwise 111 is reserved and returns 0.
module pipelined_alu #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [2:0]       sel_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned N_ITER = WIDTH / MUL_BITS;
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
    localparam int unsigned SHW    = $clog2(WIDTH);
`ifdef ALU_MULH_EN
    localparam int unsigned ACC_W  = 2 * WIDTH;
`else
    localparam int unsigned ACC_W  = WIDTH;
`endif

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
`ifdef ALU_MULH_EN
    localparam logic [2:0] OP_MULH = 3'b111;
`endif

    // Reject parameter combinations the iterative multiplier cannot handle
    if (MUL_BITS == 0 || MUL_BITS > WIDTH || (WIDTH % MUL_BITS) != 0) begin : g_bad_mul_bits
        $error("pipelined_alu: MUL_BITS (%0d) must divide WIDTH (%0d)", MUL_BITS, WIDTH);
    end
    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_alu: WIDTH (%0d) must be a power of two >= 8", WIDTH);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;
    logic               r_busy;
`ifdef ALU_MULH_EN
    logic [WIDTH-1:0]   r_op_a;
    logic               r_b_neg;
    logic               r_is_mulh;
`endif

    logic               w_accept;
    logic               w_is_mul;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic [ACC_W-1:0]   w_mcand_init;
    logic [ACC_W-1:0]   w_pp;
    logic [ACC_W-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_mul_res;

    // Ready is combinational on out_ready_i so DONE can hand off and accept in one cycle
    assign in_ready_o  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready_i);
    assign w_accept    = in_valid_i & in_ready_o & ~flush_i;
    assign w_shamt     = op_b_i[SHW-1:0];

    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;
    assign busy_o      = r_busy;

`ifdef ALU_MULH_EN
    assign w_is_mul     = (sel_i == OP_MUL) | (sel_i == OP_MULH);
    assign w_mcand_init = {{WIDTH{op_a_i[WIDTH-1]}}, op_a_i};
`else
    assign w_is_mul     = (sel_i == OP_MUL);
    assign w_mcand_init = op_a_i;
`endif

    // Single-cycle datapath on the operands being accepted this cycle
    always_comb begin
        w_alu = '0;
        case (sel_i)
            OP_ADD:  w_alu = op_a_i + op_b_i;
            OP_AND:  w_alu = op_a_i & op_b_i;
            OP_XOR:  w_alu = op_a_i ^ op_b_i;
            OP_SLL:  w_alu = op_a_i << w_shamt;
            OP_SUB:  w_alu = op_a_i - op_b_i;
            OP_SRA:  w_alu = WIDTH'($signed(op_a_i) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    // One shift-add step: shifted multiplicand times the current multiplier digit
    assign w_pp       = r_mcand * ACC_W'(r_mplier[MUL_BITS-1:0]);
    assign w_acc_next = r_acc + w_pp;

`ifdef ALU_MULH_EN
    logic [ACC_W-1:0] w_acc_fin;
    // Multiplier digits are consumed as unsigned; a negative op_b needs a_sext * 2^WIDTH removed
    assign w_acc_fin = r_b_neg ? (w_acc_next - {r_op_a, {WIDTH{1'b0}}}) : w_acc_next;
    assign w_mul_res = r_is_mulh ? w_acc_fin[ACC_W-1:WIDTH] : w_acc_fin[WIDTH-1:0];
`else
    assign w_mul_res = w_acc_next[WIDTH-1:0];
`endif

    // Control FSM with registered result, valid and busy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ALU_MULH_EN
            r_op_a      <= '0;
            r_b_neg     <= 1'b0;
            r_is_mulh   <= 1'b0;
`endif
        end else if (flush_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_result    <= w_mul_res;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= S_MUL;
                            r_cnt       <= CNT_W'(N_ITER);
                            r_acc       <= '0;
                            r_mcand     <= w_mcand_init;
                            r_mplier    <= op_b_i;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b1;
`ifdef ALU_MULH_EN
                            r_op_a      <= op_a_i;
                            r_b_neg     <= op_b_i[WIDTH-1];
                            r_is_mulh   <= (sel_i == OP_MULH);
`endif
                        end else begin
                            r_state     <= S_DONE;
                            r_result    <= w_alu;
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_state == S_DONE && out_ready_i) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (WIDTH=32, MUL_BITS=4).
module tb_pipelined_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    pipelined_alu #(.WIDTH(32), .MUL_BITS(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .sel_i       (sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  s;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the full-width product / shifts
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (s)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a ^ b;
            3'd3: return a << b[4:0];
            3'd4: return a - b;
            3'd5: return p[31:0];
            3'd6: return 32'($signed(a) >>> b[4:0]);
`ifdef ALU_MULH_EN
            default: return p[63:32];
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] s);
`ifdef ALU_MULH_EN
        return (s == 3'd5 || s == 3'd7) ? 8 : 0;
`else
        return (s == 3'd5) ? 8 : 0;
`endif
    endfunction

    // Issue one op from IDLE with out_ready=1; caller is at posedge+1
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit is_mul;
        is_mul    = (exp_lat != 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        sel       = s;
        chk({name, "_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (is_mul) begin
                chk({name, "_busy"}, busy, 1);
                chk({name, "_inready_mul"}, in_ready, 0);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_res"}, result, exp);
        chk({name, "_busy_done"}, busy, 0);
        @(posedge clk); #1;
        chk({name, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] held;
        int    seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sel = '0;
        #12 rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inready", in_ready, 1);
        @(posedge clk); #1;

        // Directed vector table (hand-computed expectations)
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 3'd0, 32'h80000000, 0});
        vecs.push_back('{32'h00000000, 32'h00000001, 3'd4, 32'hFFFFFFFF, 0});
        vecs.push_back('{32'h00000001, 32'h00000021, 3'd3, 32'h00000002, 0});
        vecs.push_back('{32'h80000000, 32'h00000004, 3'd6, 32'hF8000000, 0});
        vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 3'd1, 32'hF000F000, 0});
        vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 32'h0FF00FF0, 0});
        vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 3'd5, 32'hFFFFFFEB, 8});
        vecs.push_back('{32'h12345678, 32'h00000000, 3'd5, 32'h00000000, 8});
`ifdef ALU_MULH_EN
        vecs.push_back('{32'h80000000, 32'h80000000, 3'd7, 32'h40000000, 8});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 3'd7, 32'hFFFFFFFF, 8});
`else
        vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 3'd7, 32'h00000000, 0});
`endif
        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].lat);

        // Back-to-back add then sub with out_ready held high
        out_ready = 1'b1;
        in_valid = 1'b1; op_a = 32'h7FFFFFFF; op_b = 32'h1; sel = 3'd0;
        @(posedge clk); #1;
        chk("b2b_v1", out_valid, 1);
        chk("b2b_r1", result, 32'h80000000);
        chk("b2b_ready", in_ready, 1);
        op_a = 32'h0; op_b = 32'h1; sel = 3'd4;
        @(posedge clk); #1;
        chk("b2b_v2", out_valid, 1);
        chk("b2b_r2", result, 32'hFFFFFFFF);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle", out_valid, 0);

        // Backpressure: result held while out_ready=0, waiting input not taken
        out_ready = 1'b0;
        in_valid = 1'b1; op_a = 32'hF0F0F0F0; op_b = 32'hFF00FF00; sel = 3'd1;
        @(posedge clk); #1;
        sel = 3'd2;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_v%0d", c), out_valid, 1);
            chk($sformatf("bp_r%0d", c), result, 32'hF000F000);
            chk($sformatf("bp_rdy%0d", c), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_rdy_release", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_next_v", out_valid, 1);
        chk("bp_next_r", result, 32'h0FF00FF0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Flush in IDLE blocks a simultaneous input
        flush = 1'b1; in_valid = 1'b1; op_a = 32'h5; op_b = 32'h6; sel = 3'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_v", out_valid, 0);
        chk("flush_idle_r", result, 32'h0FF00FF0);

        // Flush during MUL cycle 4: op dropped, result keeps last value
        in_valid = 1'b1; op_a = 32'hFFFFFFFD; op_b = 32'h7; sel = 3'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("flush_mul_busy", busy, 1);
        held = result;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_mul_ready", in_ready, 1);
        chk("flush_mul_busy0", busy, 0);
        chk("flush_mul_keep", result, held);
        seen = 0;
        repeat (12) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("flush_mul_noresult", seen, 0);

        // Async reset mid-MUL (between edges, third MUL cycle)
        in_valid = 1'b1; op_a = 32'hFFFFFFFD; op_b = 32'h7; sel = 3'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        chk("rstmul_valid", out_valid, 0);
        chk("rstmul_busy", busy, 0);
        chk("rstmul_result", result, 0);
        #2 rst = 1'b0;
        #1 chk("rstmul_ready", in_ready, 1);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("rstmul_noresult", seen, 0);

        // Random ops against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, b;
            logic [2:0]  s;
            a = $urandom;
            b = $urandom;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            do_op($sformatf("rnd%0d_op%0d", n, s), a, b, s, ref_alu(a, b, s), ref_lat(s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
